// File: rtl/clock_switch_sequencer.sv
// Glitch-free source-enable switcher: drains the old divided enable, waits a quiet gap,
// then re-arms on a pulse of the new source so downstream capture never sees a runt.
module clock_switch_sequencer #(
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       sel_req,
    input  logic [1:0] sel_new,
    output logic       sel_ack,
    output logic       busy,
    output logic [1:0] cur_sel,
    output logic [3:0] src_en,
    output logic       gated_en,
    output logic [7:0] switch_cnt,
    output logic       req_err
);

    typedef enum logic [1:0] {RUN, DRAIN, ALIGN} state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] div_cnt_q, div_cnt_d;
    logic [1:0] cur_sel_q, cur_sel_d;
    logic [1:0] target_q, target_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] switch_cnt_q, switch_cnt_d;
    logic       sel_ack_q, sel_ack_d;
    logic       req_err_q, req_err_d;

    assign src_en     = {&div_cnt_q[3:0], &div_cnt_q[2:0], &div_cnt_q[1:0], div_cnt_q[0]};
    assign busy       = (state_q != RUN);
    assign gated_en   = (state_q == RUN) && src_en[cur_sel_q];
    assign cur_sel    = cur_sel_q;
    assign switch_cnt = switch_cnt_q;
    assign sel_ack    = sel_ack_q;
    assign req_err    = req_err_q;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q + 4'd1;
        cur_sel_d    = cur_sel_q;
        target_d     = target_q;
        gap_d        = gap_q;
        switch_cnt_d = switch_cnt_q;
        sel_ack_d    = 1'b0;
        req_err_d    = 1'b0;

        case (state_q)
            RUN: begin
                if (sel_req) begin
                    if (sel_new == cur_sel_q) begin
                        sel_ack_d = 1'b1;
                    end else begin
                        target_d = sel_new;
                        gap_d    = GAP_LOAD;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (gap_q == 4'd0) begin
                    state_d = ALIGN;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ALIGN: begin
                // Arm on the target's own pulse so its first gated pulse is a full period away
                if (src_en[target_q]) begin
                    state_d   = RUN;
                    cur_sel_d = target_q;
                    sel_ack_d = 1'b1;
                    if (switch_cnt_q != 8'hFF) begin
                        switch_cnt_d = switch_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // A request landing on the completing ALIGN cycle is dropped silently so ack and err stay exclusive
        if (busy && sel_req && !sel_ack_d) begin
            req_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            div_cnt_q    <= 4'd0;
            cur_sel_q    <= 2'd0;
            target_q     <= 2'd0;
            gap_q        <= 4'd0;
            switch_cnt_q <= 8'd0;
            sel_ack_q    <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            cur_sel_q    <= cur_sel_d;
            target_q     <= target_d;
            gap_q        <= gap_d;
            switch_cnt_q <= switch_cnt_d;
            sel_ack_q    <= sel_ack_d;
            req_err_q    <= req_err_d;
        end
    end

endmodule
